// File: rtl/ones_frame_accum.sv
// Frame accumulator: sums per-byte ones counts and counts beats until in_last, then holds
// the result until it is accepted. Define ONES_ACCUM_SAT_EN to clamp instead of wrap.
module ones_frame_accum #(
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_ones,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_total,
  output logic [CNT_W-1:0] out_bytes,
  output logic             out_sat
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_total_q, acc_total_d, acc_bytes_q, acc_bytes_d;
  logic [CNT_W-1:0] out_total_q, out_total_d, out_bytes_q, out_bytes_d;
  logic [CNT_W-1:0] base_total, base_bytes, sum_total, sum_bytes;
  logic             accept, load_last, load_acc, release_hold;

  assign in_ready     = (state_q != HOLD);
  assign out_valid    = (state_q == HOLD);
  assign accept       = in_valid & in_ready;
  assign load_last    = accept & in_last;
  assign load_acc     = accept & ~in_last;
  assign release_hold = (state_q == HOLD) & out_ready;

  // A frame starting from IDLE always begins from zero.
  assign base_total = (state_q == ACCUM) ? acc_total_q : '0;
  assign base_bytes = (state_q == ACCUM) ? acc_bytes_q : '0;

`ifdef ONES_ACCUM_SAT_EN
  logic [CNT_W:0] wide_total, wide_bytes;
  logic           acc_sat_q, acc_sat_d, out_sat_q, out_sat_d, base_sat, sum_sat;

  assign wide_total = {1'b0, base_total} + (CNT_W + 1)'(in_ones);
  assign wide_bytes = {1'b0, base_bytes} + (CNT_W + 1)'(1);
  assign sum_total  = wide_total[CNT_W] ? '1 : wide_total[CNT_W-1:0];
  assign sum_bytes  = wide_bytes[CNT_W] ? '1 : wide_bytes[CNT_W-1:0];
  assign base_sat   = (state_q == ACCUM) & acc_sat_q;
  // Sticky for the frame: once either accumulator clamps, the result is flagged.
  assign sum_sat    = base_sat | wide_total[CNT_W] | wide_bytes[CNT_W];

  always_comb begin
    acc_sat_d = acc_sat_q;
    out_sat_d = out_sat_q;
    if (load_last) begin
      out_sat_d = sum_sat;
      acc_sat_d = 1'b0;
    end else if (load_acc) begin
      acc_sat_d = sum_sat;
    end else if (release_hold) begin
      acc_sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sat_q <= 1'b0;
      out_sat_q <= 1'b0;
    end else begin
      acc_sat_q <= acc_sat_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign out_sat = out_sat_q;
`else
  assign sum_total = base_total + CNT_W'(in_ones);
  assign sum_bytes = base_bytes + CNT_W'(1);
  assign out_sat   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_total_d = acc_total_q;
    acc_bytes_d = acc_bytes_q;
    out_total_d = out_total_q;
    out_bytes_d = out_bytes_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (load_last) begin
          state_d     = HOLD;
          out_total_d = sum_total;
          out_bytes_d = sum_bytes;
          acc_total_d = '0;
          acc_bytes_d = '0;
        end else if (load_acc) begin
          state_d     = ACCUM;
          acc_total_d = sum_total;
          acc_bytes_d = sum_bytes;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          acc_total_d = '0;
          acc_bytes_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_total_q <= '0;
      acc_bytes_q <= '0;
      out_total_q <= '0;
      out_bytes_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_total_q <= acc_total_d;
      acc_bytes_q <= acc_bytes_d;
      out_total_q <= out_total_d;
      out_bytes_q <= out_bytes_d;
    end
  end

  assign out_total = out_total_q;
  assign out_bytes = out_bytes_q;

endmodule
